// File: rtl/codificador_teclado_debounce_if.sv
// rtl/codificador_teclado_debounce_if.sv - keypad-side and timer-side signal bundle for the debounce encoder
//
// Purpose: groups the raw keypad lines, the press enable and the encoded
// outputs that feed the timer digit registers.
//
// Signals:
//   teclado_microondas [N_TECLAS] raw key lines, 1 = pressed
//   enablen                       active-low enable for press events
//   saida_cod          [COD_W]    code of the last accepted key
//   loadn                         active-low one-cycle strobe for a new saida_cod
//   tecla_ativa                   high while a debounced key is held
//   multipla                      more than one line set at the accept instant
//
// Modports:
//   master - keypad/timer side (drives keys and enable, receives code)
//   slave  - the encoder itself
interface codificador_teclado_debounce_if #(
    parameter int N_TECLAS = 10,
    parameter int COD_W    = 4
);
    logic [N_TECLAS-1:0] teclado_microondas;
    logic                enablen;
    logic [COD_W-1:0]    saida_cod;
    logic                loadn;
    logic                tecla_ativa;
    logic                multipla;

    modport master (
        output teclado_microondas,
        output enablen,
        input  saida_cod,
        input  loadn,
        input  tecla_ativa,
        input  multipla
    );

    modport slave (
        input  teclado_microondas,
        input  enablen,
        output saida_cod,
        output loadn,
        output tecla_ativa,
        output multipla
    );
endinterface

// File: rtl/codificador_teclado_debounce.sv
// rtl/codificador_teclado_debounce.sv - debounced priority encoder for the microwave keypad
//
// Purpose: registers the raw keypad lines, filters contact bounce on press
// and on release, and on each accepted press emits the highest pressed key
// index as a binary code with a one-cycle active-low load strobe.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - codificador_teclado_debounce_if.slave
//            (teclado_microondas, enablen in; saida_cod, loadn,
//             tecla_ativa, multipla out)
//
// Optional feature macro: TECLADO_REPETICAO_EN
//   defined   - while a key stays held with enablen low, loadn is re-strobed
//               every REPETE_CICLOS clocks carrying the currently held code
//   undefined - one strobe per press, no repeat counter
module codificador_teclado_debounce #(
    parameter int N_TECLAS        = 10,
    parameter int COD_W           = 4,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int REPETE_CICLOS   = 1000
) (
    input  logic                          clock,
    input  logic                          reset,
    codificador_teclado_debounce_if.slave bus
);

    localparam int                  CNT_W         = $clog2(DEBOUNCE_CICLOS + 1);
    localparam bit                  ACEITA_DIRETO = (DEBOUNCE_CICLOS == 1);
    localparam logic [N_TECLAS-1:0] UM            = N_TECLAS'(1);

    if (DEBOUNCE_CICLOS < 1 || REPETE_CICLOS < 1 || (1 << COD_W) < N_TECLAS) begin : g_parametro_invalido
        $error("codificador_teclado_debounce: invalid parameter set");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRO,
        PRESSIONADO,
        SOLTURA
    } estado_t;

    estado_t             estado;
    logic [N_TECLAS-1:0] tec_r;
    logic [COD_W-1:0]    cod_atual;
    logic [COD_W-1:0]    cod_cand;
    logic                algum;
    logic                varias;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;

    logic [COD_W-1:0]    saida_cod_r;
    logic                loadn_r;
    logic                tecla_ativa_r;
    logic                multipla_r;

`ifdef TECLADO_REPETICAO_EN
    localparam int REP_W = $clog2(REPETE_CICLOS + 1);
    logic [REP_W-1:0] rep_cnt;
`endif

    // Later (higher) indices overwrite earlier ones, so the highest pressed
    // line wins.
    always_comb begin
        cod_atual = '0;
        for (int i = 0; i < N_TECLAS; i++) begin
            if (tec_r[i]) begin
                cod_atual = COD_W'(i);
            end
        end
    end

    assign algum   = |tec_r;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign varias  = |(tec_r & (tec_r - UM));
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            tec_r         <= '0;
            estado        <= OCIOSO;
            cnt           <= '0;
            cod_cand      <= '0;
            saida_cod_r   <= '0;
            loadn_r       <= 1'b1;
            tecla_ativa_r <= 1'b0;
            multipla_r    <= 1'b0;
`ifdef TECLADO_REPETICAO_EN
            rep_cnt       <= '0;
`endif
        end else begin
            tec_r   <= bus.teclado_microondas;
            // The strobe is only ever asserted for the single edge that sets it.
            loadn_r <= 1'b1;

            case (estado)
                OCIOSO: begin
                    if (algum && !bus.enablen) begin
                        cod_cand <= cod_atual;
                        cnt      <= CNT_W'(1);
                        if (ACEITA_DIRETO) begin
                            // One matching sample already satisfies the filter.
                            estado        <= PRESSIONADO;
                            saida_cod_r   <= cod_atual;
                            loadn_r       <= 1'b0;
                            tecla_ativa_r <= 1'b1;
                            multipla_r    <= varias;
`ifdef TECLADO_REPETICAO_EN
                            rep_cnt       <= '0;
`endif
                        end else begin
                            estado <= FILTRO;
                        end
                    end
                end

                FILTRO: begin
                    // Any disagreement aborts; the disagreeing sample does not
                    // seed a new candidate, OCIOSO picks up from the next one.
                    if (bus.enablen || !algum || (cod_atual != cod_cand)) begin
                        estado <= OCIOSO;
                        cnt    <= '0;
                    end else if (cnt_inc == CNT_W'(DEBOUNCE_CICLOS)) begin
                        estado        <= PRESSIONADO;
                        cnt           <= '0;
                        saida_cod_r   <= cod_cand;
                        loadn_r       <= 1'b0;
                        tecla_ativa_r <= 1'b1;
                        multipla_r    <= varias;
`ifdef TECLADO_REPETICAO_EN
                        rep_cnt       <= '0;
`endif
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                PRESSIONADO: begin
                    // Code changes while held are ignored; only full release
                    // (all lines low) is tracked, regardless of enablen.
                    if (!algum) begin
`ifdef TECLADO_REPETICAO_EN
                        rep_cnt <= '0;
`endif
                        if (ACEITA_DIRETO) begin
                            estado        <= OCIOSO;
                            cnt           <= '0;
                            tecla_ativa_r <= 1'b0;
                        end else begin
                            estado <= SOLTURA;
                            cnt    <= CNT_W'(1);
                        end
                    end
`ifdef TECLADO_REPETICAO_EN
                    else if (bus.enablen) begin
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_W'(REPETE_CICLOS - 1)) begin
                        rep_cnt     <= '0;
                        loadn_r     <= 1'b0;
                        saida_cod_r <= cod_atual;
                        multipla_r  <= varias;
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
`endif
                end

                SOLTURA: begin
                    if (algum) begin
                        // Release bounce: key is still considered held, no strobe.
                        estado <= PRESSIONADO;
                        cnt    <= '0;
                    end else if (cnt_inc == CNT_W'(DEBOUNCE_CICLOS)) begin
                        estado        <= OCIOSO;
                        cnt           <= '0;
                        tecla_ativa_r <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                default: begin
                    estado <= OCIOSO;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.saida_cod   = saida_cod_r;
    assign bus.loadn       = loadn_r;
    assign bus.tecla_ativa = tecla_ativa_r;
    assign bus.multipla    = multipla_r;

endmodule

// File: tb/tb_codificador_teclado_debounce.sv
// tb/tb_codificador_teclado_debounce.sv - self-checking bench for codificador_teclado_debounce
module tb_codificador_teclado_debounce;

    localparam int N   = 10;
    localparam int W   = 4;
    localparam int DEB = 4;
    localparam int REP = 10;

    logic clock;
    logic reset;

    int n_vec;
    int n_err;

    codificador_teclado_debounce_if #(.N_TECLAS(N), .COD_W(W)) bus ();

    codificador_teclado_debounce #(
        .N_TECLAS       (N),
        .COD_W          (W),
        .DEBOUNCE_CICLOS(DEB),
        .REPETE_CICLOS  (REP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model, phrased as runs of agreeing samples.
    // m_tec is the sample the design sees (input delayed by one edge).
    logic [N-1:0] m_tec;
    logic         m_held;
    int           m_run;   // consecutive accepted-candidate samples while not held
    int           m_cand;
    int           m_gap;   // consecutive empty samples while held
    int           m_rep;
    logic [W-1:0] m_cod;
    logic         m_load;
    logic         m_ativa;
    logic         m_mult;

    task automatic model_edge(input logic [N-1:0] tec_in, input logic en_n, input logic rst);
        int top;
        int ones;
        top  = -1;
        ones = 0;
        for (int i = 0; i < N; i++) begin
            if (m_tec[i]) begin
                top = i;
                ones++;
            end
        end
        m_load = 1'b1;
        if (rst) begin
            m_tec = '0; m_held = 1'b0; m_run = 0; m_cand = 0; m_gap = 0; m_rep = 0;
            m_cod = '0; m_ativa = 1'b0; m_mult = 1'b0;
            return;
        end
        if (!m_held) begin
            if (top >= 0 && !en_n && (m_run == 0 || top == m_cand)) begin
                if (m_run == 0) m_cand = top;
                m_run++;
                if (m_run >= DEB) begin
                    m_held = 1'b1; m_run = 0; m_gap = 0; m_rep = 0;
                    m_cod = W'(m_cand); m_load = 1'b0; m_ativa = 1'b1; m_mult = (ones > 1);
                end
            end else if (m_run > 0) begin
                m_run = 0;
            end
        end else begin
            if (top < 0) begin
                m_gap++;
                m_rep = 0;
                if (m_gap >= DEB) begin
                    m_held = 1'b0; m_gap = 0; m_ativa = 1'b0;
                end
            end else if (m_gap > 0) begin
                m_gap = 0;
            end else begin
`ifdef TECLADO_REPETICAO_EN
                if (en_n) begin
                    m_rep = 0;
                end else begin
                    m_rep++;
                    if (m_rep == REP) begin
                        m_rep = 0; m_load = 1'b0; m_cod = W'(top); m_mult = (ones > 1);
                    end
                end
`endif
            end
        end
        m_tec = tec_in;
    endtask

    task automatic tick(input logic [N-1:0] tec, input logic en_n, input logic rst);
        bus.teclado_microondas = tec;
        bus.enablen            = en_n;
        reset                  = rst;
        model_edge(tec, en_n, rst);
        @(posedge clock);
        #1;
    endtask

    task automatic descanso(input int n);
        for (int c = 0; c < n; c++) begin
            tick('0, 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin
                n_err++;
                $display("FAIL idle_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load);
            end
        end
    endtask

    task automatic test_reset();
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        n_vec++;
        if (bus.saida_cod !== 4'd0) begin n_err++; $display("FAIL reset_cod got %0d exp 0", bus.saida_cod); end
        n_vec++;
        if (bus.loadn !== 1'b1) begin n_err++; $display("FAIL reset_loadn got %b exp 1", bus.loadn); end
        n_vec++;
        if (bus.tecla_ativa !== 1'b0) begin n_err++; $display("FAIL reset_ativa got %b exp 0", bus.tecla_ativa); end
        n_vec++;
        if (bus.multipla !== 1'b0) begin n_err++; $display("FAIL reset_mult got %b exp 0", bus.multipla); end
    endtask

    task automatic test_clean_press();
        int strobes;
        int first;
        strobes = 0;
        first   = -1;
        for (int c = 0; c < 20; c++) begin
            tick(10'd1 << 3, 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL clean_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            if (bus.loadn === 1'b0) begin
                strobes++;
                if (first < 0) first = c;
            end
        end
        n_vec++;
        if (strobes != 1) begin n_err++; $display("FAIL clean_strobes got %0d exp 1", strobes); end
        n_vec++;
        if (first != DEB) begin n_err++; $display("FAIL clean_latency got %0d exp %0d", first, DEB); end
        n_vec++;
        if (bus.saida_cod !== 4'd3) begin n_err++; $display("FAIL clean_cod got %0d exp 3", bus.saida_cod); end
        n_vec++;
        if (bus.tecla_ativa !== 1'b1) begin n_err++; $display("FAIL clean_ativa got %b exp 1", bus.tecla_ativa); end
        n_vec++;
        if (bus.multipla !== 1'b0) begin n_err++; $display("FAIL clean_mult got %b exp 0", bus.multipla); end
        descanso(10);
    endtask

    task automatic test_bounce();
        logic [4:0] padrao;
        int strobes;
        int first;
        padrao  = 5'b01101;   // applied LSB first: 1,0,1,1,0
        strobes = 0;
        first   = -1;
        for (int c = 0; c < 20; c++) begin
            tick((c < 5 && !padrao[c]) ? 10'd0 : (10'd1 << 7), 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL bounce_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            if (bus.loadn === 1'b0) begin
                strobes++;
                if (first < 0) first = c;
            end
        end
        n_vec++;
        if (strobes != 1) begin n_err++; $display("FAIL bounce_strobes got %0d exp 1", strobes); end
        n_vec++;
        if (first != 5 + DEB) begin n_err++; $display("FAIL bounce_latency got %0d exp %0d", first, 5 + DEB); end
        n_vec++;
        if (bus.saida_cod !== 4'd7) begin n_err++; $display("FAIL bounce_cod got %0d exp 7", bus.saida_cod); end
        descanso(10);
    endtask

    task automatic test_priority();
        int strobes;
        strobes = 0;
        for (int c = 0; c < 22; c++) begin
            tick((c < 12) ? ((10'd1 << 2) | (10'd1 << 9)) : (10'd1 << 2), 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL prio_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            if (bus.loadn === 1'b0) strobes++;
            if (c == 11) begin
                n_vec++;
                if (bus.saida_cod !== 4'd9) begin n_err++; $display("FAIL prio_cod got %0d exp 9", bus.saida_cod); end
                n_vec++;
                if (bus.multipla !== 1'b1) begin n_err++; $display("FAIL prio_mult got %b exp 1", bus.multipla); end
            end
        end
        n_vec++;
        if (strobes != 1) begin n_err++; $display("FAIL prio_strobes got %0d exp 1", strobes); end
        n_vec++;
        if (bus.saida_cod !== 4'd9) begin n_err++; $display("FAIL prio_hold_cod got %0d exp 9", bus.saida_cod); end
        n_vec++;
        if (bus.tecla_ativa !== 1'b1) begin n_err++; $display("FAIL prio_ativa got %b exp 1", bus.tecla_ativa); end
        descanso(10);
    endtask

    task automatic test_release_bounce();
        int strobes;
        int fall;
        strobes = 0;
        fall    = -1;
        for (int c = 0; c < 24; c++) begin
            tick((c < 8 || c == 10 || c == 11) ? (10'd1 << 5) : 10'd0, 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL rel_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            n_vec++;
            if (bus.tecla_ativa !== m_ativa) begin n_err++; $display("FAIL rel_ativa cyc %0d got %b exp %b", c, bus.tecla_ativa, m_ativa); end
            if (bus.loadn === 1'b0) strobes++;
            if (c > DEB && fall < 0 && bus.tecla_ativa === 1'b0) fall = c;
        end
        n_vec++;
        if (strobes != 1) begin n_err++; $display("FAIL rel_strobes got %0d exp 1", strobes); end
        n_vec++;
        if (fall != 12 + DEB) begin n_err++; $display("FAIL rel_fall got %0d exp %0d", fall, 12 + DEB); end
        n_vec++;
        if (bus.saida_cod !== 4'd5) begin n_err++; $display("FAIL rel_cod got %0d exp 5", bus.saida_cod); end
    endtask

    task automatic test_enable_reset();
        int strobes;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            tick(10'd1 << 4, 1'b1, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL en_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            if (bus.loadn === 1'b0) strobes++;
        end
        n_vec++;
        if (strobes != 0) begin n_err++; $display("FAIL en_strobes got %0d exp 0", strobes); end
        n_vec++;
        if (bus.saida_cod !== 4'd5) begin n_err++; $display("FAIL en_cod got %0d exp 5", bus.saida_cod); end
        descanso(8);
        // Reach the filter with key 6, then reset mid-filter.
        tick(10'd1 << 6, 1'b0, 1'b0);
        tick(10'd1 << 6, 1'b0, 1'b0);
        tick(10'd1 << 6, 1'b0, 1'b0);
        tick(10'd1 << 6, 1'b0, 1'b1);
        n_vec++;
        if (bus.loadn !== 1'b1) begin n_err++; $display("FAIL rstf_loadn got %b exp 1", bus.loadn); end
        n_vec++;
        if (bus.saida_cod !== 4'd0) begin n_err++; $display("FAIL rstf_cod got %0d exp 0", bus.saida_cod); end
        n_vec++;
        if (bus.tecla_ativa !== 1'b0) begin n_err++; $display("FAIL rstf_ativa got %b exp 0", bus.tecla_ativa); end
        n_vec++;
        if (bus.multipla !== 1'b0) begin n_err++; $display("FAIL rstf_mult got %b exp 0", bus.multipla); end
        descanso(8);
    endtask

`ifdef TECLADO_REPETICAO_EN
    task automatic test_repeat();
        int strobes;
        int last;
        strobes = 0;
        last    = -1;
        for (int c = 0; c < DEB + 1 + 45; c++) begin
            tick(10'd1 << 1, 1'b0, 1'b0);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL rep_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            if (bus.loadn === 1'b0) begin
                strobes++;
                n_vec++;
                if (bus.saida_cod !== 4'd1) begin n_err++; $display("FAIL rep_cod cyc %0d got %0d exp 1", c, bus.saida_cod); end
                if (last >= 0) begin
                    n_vec++;
                    if (c - last != REP) begin n_err++; $display("FAIL rep_gap got %0d exp %0d", c - last, REP); end
                end
                last = c;
            end
        end
        n_vec++;
        if (strobes != 5) begin n_err++; $display("FAIL rep_strobes got %0d exp 5", strobes); end
        descanso(10);
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] pad;
        logic         en_n;
        logic         rst;
        pad = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       pad = '0;
                    1:       pad = 10'd1 << $urandom_range(0, N - 1);
                    2:       pad = (10'd1 << $urandom_range(0, N - 1)) | (10'd1 << $urandom_range(0, N - 1));
                    default: pad = 10'($urandom);
                endcase
            end
            en_n = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 249) == 0);
            tick(pad, en_n, rst);
            n_vec++;
            if (bus.loadn !== m_load) begin n_err++; $display("FAIL rnd_loadn cyc %0d got %b exp %b", c, bus.loadn, m_load); end
            n_vec++;
            if (bus.saida_cod !== m_cod) begin n_err++; $display("FAIL rnd_cod cyc %0d got %0d exp %0d", c, bus.saida_cod, m_cod); end
            n_vec++;
            if (bus.tecla_ativa !== m_ativa) begin n_err++; $display("FAIL rnd_ativa cyc %0d got %b exp %b", c, bus.tecla_ativa, m_ativa); end
            n_vec++;
            if (bus.multipla !== m_mult) begin n_err++; $display("FAIL rnd_mult cyc %0d got %b exp %b", c, bus.multipla, m_mult); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.teclado_microondas = '0;
        bus.enablen = 1'b0;
        m_tec = '0; m_held = 1'b0; m_run = 0; m_cand = 0; m_gap = 0; m_rep = 0;
        m_cod = '0; m_load = 1'b1; m_ativa = 1'b0; m_mult = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_release_bounce();
        test_enable_reset();
`ifdef TECLADO_REPETICAO_EN
        test_repeat();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
